// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor
//   Watches an asynchronous checkbits bus for a programmed, ordered sequence of codes with a
//   per-stage cycle timeout, and reports busy/pass/fail plus a fail reason.
//
//   Build option: define STRICT_ORDER_EN to fail on any out-of-order code (fail_code 2'b10).
//   Left undefined, codes that do not match the current stage are ignored.
//
// Ports
//   clock          single clock, all logic on posedge
//   resetb         synchronous active-low reset
//   cfg_we         expected-code table write strobe (ignored while busy)
//   cfg_addr       table index
//   cfg_data       expected code
//   seq_len        entries to match, clamped to DEPTH, sampled on start
//   timeout_cycles per-stage cycle limit, 0 disables, sampled on start
//   start          arm pulse, honoured in any state
//   checkbits      observed code bus, asynchronous to clock
//   busy           monitor armed
//   pass           sticky: full sequence matched
//   fail           sticky: timeout or order violation
//   fail_code      00 none, 01 timeout, 10 out-of-order
//   stage          entries matched so far
module checkpoint_seq_monitor #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned STABLE    = 2,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WIDTH-1:0]     cfg_data,
  input  logic [AW:0]          seq_len,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 start,
  input  logic [WIDTH-1:0]     checkbits,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [AW:0]          stage
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StPass  = 2'd2;
  localparam logic [1:0] StFail  = 2'd3;

  localparam int unsigned CW        = $clog2(STABLE + 1);
  localparam logic [CW-1:0] StableCnt = CW'(STABLE);
  localparam logic [AW:0]   DepthVal  = (AW + 1)'(DEPTH);

  // Input synchroniser and stability filter
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             evt;

  // cand_q is the value being qualified; cnt_q counts consecutive cycles it has been seen.
  // An event fires on the edge the count reaches STABLE with a value different from filt_q.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    evt    = 1'b0;
    if (sync2_q == cand_q) begin
      if (cnt_q != StableCnt) cnt_d = cnt_q + 1'b1;
    end else begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
    end
    if (cnt_d == StableCnt && sync2_q != filt_q) begin
      filt_d = sync2_q;
      evt    = 1'b1;
    end
  end

  // Sequence FSM
  logic [WIDTH-1:0]     code_tbl_q [DEPTH];
  logic [1:0]           state_q, state_d;
  logic [AW:0]          stage_q, stage_d;
  logic [AW:0]          len_q, len_d;
  logic [AW:0]          len_clamped;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [TIMEOUT_W-1:0] timer_inc;
  logic [1:0]           fail_code_q, fail_code_d;
  logic [WIDTH-1:0]     cur_code;
  logic                 match;

  assign len_clamped = (seq_len > DepthVal) ? DepthVal : seq_len;
  assign cur_code    = code_tbl_q[stage_q[AW-1:0]];
  assign match       = evt && (filt_d == cur_code);
  // Saturating increment
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;

`ifdef STRICT_ORDER_EN
  logic [AW-1:0]    prev_idx;
  logic [WIDTH-1:0] prev_code;
  logic             order_err;

  assign prev_idx  = stage_q[AW-1:0] - 1'b1;
  assign prev_code = code_tbl_q[prev_idx];
  // A repeat of the code just matched is tolerated; anything else is out of order.
  assign order_err = evt && !match && !(stage_q != '0 && filt_d == prev_code);
`endif

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    len_d       = len_q;
    tmo_d       = tmo_q;
    timer_d     = timer_q;
    fail_code_d = fail_code_q;
    if (start) begin
      // Start wins over any coincident event, which is dropped.
      state_d     = (len_clamped == '0) ? StPass : StArmed;
      stage_d     = '0;
      timer_d     = '0;
      fail_code_d = 2'b00;
      len_d       = len_clamped;
      tmo_d       = timeout_cycles;
    end else if (state_q == StArmed) begin
      if (match) begin
        // Match beats a timeout landing on the same edge.
        stage_d = stage_q + 1'b1;
        timer_d = '0;
        if (stage_q + 1'b1 == len_q) state_d = StPass;
`ifdef STRICT_ORDER_EN
      end else if (order_err) begin
        state_d     = StFail;
        fail_code_d = 2'b10;
`endif
      end else begin
        timer_d = timer_inc;
        if (tmo_q != '0 && timer_inc >= tmo_q) begin
          state_d     = StFail;
          fail_code_d = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      filt_q      <= '0;
      state_q     <= StIdle;
      stage_q     <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      timer_q     <= '0;
      fail_code_q <= 2'b00;
    end else begin
      sync1_q     <= checkbits;
      sync2_q     <= sync1_q;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      state_q     <= state_d;
      stage_q     <= stage_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      timer_q     <= timer_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Table is deliberately not reset so it survives a test-level reset.
  always_ff @(posedge clock) begin
    if (cfg_we && state_q != StArmed) code_tbl_q[cfg_addr] <= cfg_data;
  end

  assign busy      = (state_q == StArmed);
  assign pass      = (state_q == StPass);
  assign fail      = (state_q == StFail);
  assign fail_code = fail_code_q;
  assign stage     = stage_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// tb_checkpoint_seq_monitor
//   Directed bench for checkpoint_seq_monitor with default parameters (WIDTH 16, DEPTH 8,
//   STABLE 2). Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_checkpoint_seq_monitor;

  logic        clock;
  logic        resetb;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [3:0]  seq_len;
  logic [23:0] timeout_cycles;
  logic        start;
  logic [15:0] checkbits;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [3:0]  stage;

  int checks = 0;
  int errors = 0;

  checkpoint_seq_monitor dut (
    .clock          (clock),
    .resetb         (resetb),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .seq_len        (seq_len),
    .timeout_cycles (timeout_cycles),
    .start          (start),
    .checkbits      (checkbits),
    .busy           (busy),
    .pass           (pass),
    .fail           (fail),
    .fail_code      (fail_code),
    .stage          (stage)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic arm(input logic [3:0] len, input logic [23:0] tmo);
    seq_len        = len;
    timeout_cycles = tmo;
    start          = 1'b1;
    tick(1);
    start          = 1'b0;
  endtask

  // Pin change to accepted event takes 2+STABLE = 4 edges.
  task automatic drive_accept(input string tag, input logic [15:0] c, input int exp_stage);
    checkbits = c;
    tick(3);
    check({tag, "_pre"}, stage, exp_stage - 1);
    tick(1);
    check({tag, "_acc"}, stage, exp_stage);
  endtask

  logic [15:0] codes [8];

  initial begin
    codes = '{16'hA040, 16'hA041, 16'hA042, 16'hA090,
              16'hB000, 16'hB001, 16'hB002, 16'hB003};
    resetb = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    seq_len = '0; timeout_cycles = '0; start = 1'b0; checkbits = '0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_code", fail_code, 0);
    check("rst_stage", stage, 0);
    resetb = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) write_entry(3'(i), codes[i]);

    // T1: in-order sequence, no timeout, codes 20 cycles apart
    arm(4'd4, 24'd0);
    check("t1_busy", busy, 1);
    check("t1_stage0", stage, 0);
    for (int i = 0; i < 4; i++) begin
      drive_accept("t1", codes[i], i + 1);
      if (i < 3) begin
        check("t1_notpass", pass, 0);
        tick(16);
      end
    end
    check("t1_pass", pass, 1);
    check("t1_busy_end", busy, 0);
    check("t1_fail", fail, 0);

    // T2: timeout exactly 50 cycles after the A041 accept
    arm(4'd4, 24'd50);
    drive_accept("t2a", 16'hA040, 1);
    drive_accept("t2b", 16'hA041, 2);
    tick(49);
    check("t2_nofail49", fail, 0);
    check("t2_busy49", busy, 1);
    tick(1);
    check("t2_fail", fail, 1);
    check("t2_code", fail_code, 2'b01);
    check("t2_stage", stage, 2);
    check("t2_busy", busy, 0);

    // T3: stray code 1234 in the middle
    arm(4'd4, 24'd0);
    check("t3_code_clr", fail_code, 0);
    drive_accept("t3a", 16'hA040, 1);
    checkbits = 16'h1234;
    tick(4);
`ifdef STRICT_ORDER_EN
    check("t3_fail", fail, 1);
    check("t3_code", fail_code, 2'b10);
    check("t3_stage", stage, 1);
`else
    check("t3_busy", busy, 1);
    check("t3_stage", stage, 1);
    drive_accept("t3b", 16'hA041, 2);
    drive_accept("t3c", 16'hA042, 3);
    drive_accept("t3d", 16'hA090, 4);
    check("t3_pass", pass, 1);
    check("t3_code", fail_code, 0);
`endif

    // T4: one-cycle glitch is filtered out
    arm(4'd4, 24'd0);
    drive_accept("t4a", 16'hA040, 1);
    checkbits = 16'hA041;
    tick(1);
    checkbits = 16'hA040;
    tick(8);
    check("t4_stage", stage, 1);
    check("t4_busy", busy, 1);
    drive_accept("t4b", 16'hA041, 2);

    // T5: reset at stage 2 aborts without flags, then a clean rerun
    resetb = 1'b0;
    tick(1);
    resetb = 1'b1;
    check("t5_busy", busy, 0);
    check("t5_pass", pass, 0);
    check("t5_fail", fail, 0);
    check("t5_stage", stage, 0);
    tick(6);
    arm(4'd4, 24'd0);
    for (int i = 0; i < 4; i++) drive_accept("t5", codes[i], i + 1);
    check("t5_pass_end", pass, 1);

    // T6: zero-length sequence, then table write while busy is ignored
    arm(4'd0, 24'd0);
    check("t6_len0_pass", pass, 1);
    check("t6_len0_busy", busy, 0);
    check("t6_len0_stage", stage, 0);
    arm(4'd4, 24'd0);
    write_entry(3'd0, 16'h5555);
    for (int i = 0; i < 4; i++) drive_accept("t6", codes[i], i + 1);
    check("t6_pass", pass, 1);

    // seq_len above DEPTH clamps to 8 entries
    arm(4'd12, 24'd0);
    for (int i = 0; i < 8; i++) begin
      drive_accept("clamp", codes[i], i + 1);
      if (i == 6) check("clamp_busy7", busy, 1);
    end
    check("clamp_pass", pass, 1);
    check("clamp_stage", stage, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
